// File: rtl/fifod2mac.sv
// fifod2mac: moves payload bytes from fifod into the UDP TX buffer, then requests transmission.
// Ports: clk/rst; fs start level, fd done; so status (= udp_tx_addr); dev_tx_len payload count;
// fifod_rxd/fifod_empty/fifod_rxen FIFO read side; udp_txd/udp_tx_addr/udp_txen TX buffer write side;
// udp_tx_len UDP length; udp_tx_req/udp_tx_done MAC handshake.
module fifod2mac #(
  parameter int MAX_LEN = 1472,
  parameter int HDR_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fs,
  output logic        fd,
  output logic [10:0] so,
  input  logic [11:0] dev_tx_len,
  input  logic [7:0]  fifod_rxd,
  input  logic        fifod_empty,
  output logic        fifod_rxen,
  output logic [7:0]  udp_txd,
  output logic [10:0] udp_tx_addr,
  output logic        udp_txen,
  output logic [15:0] udp_tx_len,
  output logic        udp_tx_req,
  input  logic        udp_tx_done
);
  typedef enum logic [2:0] {IDLE, LOAD, WORK, SEND, LAST} state_t;
  state_t      state_q;
  logic [10:0] len_q, rd_cnt_q, addr_q;
  logic        txen_q, req_q;
  logic [15:0] tx_len_q;
  logic [10:0] clamp_len;
  assign clamp_len   = dev_tx_len > 12'(MAX_LEN) ? 11'(MAX_LEN) : dev_tx_len[10:0];
  assign fifod_rxen  = state_q == WORK && rd_cnt_q < len_q && !fifod_empty;
  assign fd          = state_q == LAST;
  assign so          = addr_q;
  assign udp_tx_addr = addr_q;
  assign udp_txd     = fifod_rxd;
  assign udp_txen    = txen_q;
  assign udp_tx_len  = tx_len_q;
  assign udp_tx_req  = req_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      rd_cnt_q <= '0;
      addr_q   <= '0;
      txen_q   <= 1'b0;
      req_q    <= 1'b0;
      tx_len_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          rd_cnt_q <= '0;
          addr_q   <= '0;
          txen_q   <= 1'b0;
          req_q    <= 1'b0;
          if (fs) begin
            len_q   <= clamp_len;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          tx_len_q <= 16'(len_q) + 16'(HDR_LEN);
          state_q  <= len_q == '0 ? LAST : WORK;
        end
        WORK: begin
          rd_cnt_q <= rd_cnt_q + 11'(fifod_rxen);
          txen_q   <= fifod_rxen;
          // the address stops on the last byte so it holds the final written address
          if (txen_q) begin
            if (addr_q == len_q - 11'd1) begin
              state_q <= SEND;
              req_q   <= 1'b1;
            end else begin
              addr_q <= addr_q + 11'd1;
            end
          end
        end
        SEND: begin
          if (udp_tx_done) begin
            req_q   <= 1'b0;
            state_q <= LAST;
          end
        end
        LAST:    state_q <= fs ? LAST : IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifod2mac.sv
// tb_fifod2mac: directed scoreboard bench for fifod2mac with a non-FWFT FIFO model.
module tb_fifod2mac;
  logic        clk = 1'b0;
  logic        rst, fs, fd, fifod_empty, fifod_rxen, udp_txen, udp_tx_req, udp_tx_done;
  logic [10:0] so, udp_tx_addr;
  logic [11:0] dev_tx_len;
  logic [7:0]  fifod_rxd, udp_txd;
  logic [15:0] udp_tx_len;
  logic        stall;
  int          fcnt, cyc, nchk, nerr, t0;
  int          rxn, wn, first_rx, first_w, last_w, last_a;
  logic [7:0]  fq[$];
  logic [18:0] sb[$];
  logic [18:0] e;

  fifod2mac dut (
    .clk(clk), .rst(rst), .fs(fs), .fd(fd), .so(so), .dev_tx_len(dev_tx_len),
    .fifod_rxd(fifod_rxd), .fifod_empty(fifod_empty), .fifod_rxen(fifod_rxen),
    .udp_txd(udp_txd), .udp_tx_addr(udp_tx_addr), .udp_txen(udp_txen),
    .udp_tx_len(udp_tx_len), .udp_tx_req(udp_tx_req), .udp_tx_done(udp_tx_done)
  );

  always #5 clk = ~clk;
  assign fifod_empty = stall || fcnt == 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifod_rxen && fq.size() > 0) begin
      fifod_rxd <= fq[0];
      fq.pop_front();
      fcnt <= fcnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fifod_rxen) begin
        if (rxn == 0) first_rx = cyc;
        rxn++;
      end
      if (udp_txen) begin
        if (sb.size() == 0) chk("extra_wr", 32'(udp_txen), 0);
        else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(udp_tx_addr), 32'(e[18:8]));
          chk("wr_data", 32'(udp_txd), 32'(e[7:0]));
        end
        if (wn == 0) first_w = cyc;
        last_w = cyc;
        last_a = 32'(udp_tx_addr);
        wn++;
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic start(input int len, input int avail);
    int n;
    logic [7:0] b;
    n = len > 1472 ? 1472 : len;
    rxn = 0; wn = 0; first_rx = -1; first_w = -1; last_w = -1; last_a = -1;
    for (int i = 0; i < avail; i++) begin
      b = 8'($urandom);
      fq.push_back(b);
      if (i < n) sb.push_back({11'(i), b});
    end
    fcnt = fcnt + avail;
    dev_tx_len = 12'(len);
    fs = 1'b1;
    t0 = cyc;
  endtask

  task automatic wait_req(input int maxc);
    int n = 0;
    while (!udp_tx_req && n < maxc) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(udp_tx_req), 1);
  endtask

  task automatic done_pulse;
    udp_tx_done = 1'b1;
    tick();
    udp_tx_done = 1'b0;
    chk("req_fall", 32'(udp_tx_req), 0);
    chk("fd_rise", 32'(fd), 1);
  endtask

  task automatic flush;
    fq.delete();
    sb.delete();
    fcnt = 0;
  endtask

  initial begin
    int n;
    rst = 1'b1; fs = 1'b0; dev_tx_len = '0; udp_tx_done = 1'b0; stall = 1'b0;
    fcnt = 0; cyc = 0; nchk = 0; nerr = 0;
    repeat (2) tick();
    chk("rst_fd", 32'(fd), 0);
    chk("rst_rxen", 32'(fifod_rxen), 0);
    chk("rst_txen", 32'(udp_txen), 0);
    chk("rst_addr", 32'(udp_tx_addr), 0);
    chk("rst_so", 32'(so), 0);
    chk("rst_len", 32'(udp_tx_len), 0);
    chk("rst_req", 32'(udp_tx_req), 0);
    rst = 1'b0;
    tick();
    udp_tx_done = 1'b1;
    tick();
    udp_tx_done = 1'b0;
    chk("idle_done_ignored", 32'(fd), 0);

    start(4, 4);
    wait_req(20);
    chk("t1_req_cyc", cyc, t0 + 7);
    chk("t1_first_rx", first_rx, t0 + 2);
    chk("t1_rxn", rxn, 4);
    chk("t1_first_w", first_w, t0 + 3);
    chk("t1_last_w", last_w, t0 + 6);
    chk("t1_wn", wn, 4);
    chk("t1_len", 32'(udp_tx_len), 12);
    chk("t1_so", 32'(so), 3);
    done_pulse();
    fs = 1'b0;
    tick();
    chk("t1_idle_fd", 32'(fd), 0);
    tick();
    chk("t1_idle_addr", 32'(udp_tx_addr), 0);

    start(6, 6);
    n = 0;
    while (rxn < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("t2_two_reads", rxn, 2);
    @(posedge clk);
    #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_req(30);
    chk("t2_rxn", rxn, 6);
    chk("t2_wn", wn, 6);
    chk("t2_span", last_w - first_w, 8);
    chk("t2_sb_empty", sb.size(), 0);
    done_pulse();
    fs = 1'b0;
    tick();

    start(0, 0);
    tick();
    tick();
    chk("t3_fd", 32'(fd), 1);
    chk("t3_rxn", rxn, 0);
    chk("t3_wn", wn, 0);
    chk("t3_req", 32'(udp_tx_req), 0);
    chk("t3_len", 32'(udp_tx_len), 8);
    fs = 1'b0;
    tick();

    start(2000, 1480);
    wait_req(1600);
    chk("t4_wn", wn, 1472);
    chk("t4_last_a", last_a, 1471);
    chk("t4_len", 32'(udp_tx_len), 1480);
    chk("t4_sb_empty", sb.size(), 0);
    done_pulse();
    fs = 1'b0;
    tick();
    flush();

    start(20, 20);
    n = 0;
    while (wn < 10 && n < 100) begin
      tick();
      n++;
    end
    chk("t5_ten_writes", wn, 10);
    rst = 1'b1;
    fs = 1'b0;
    tick();
    chk("t5_fd", 32'(fd), 0);
    chk("t5_rxen", 32'(fifod_rxen), 0);
    chk("t5_txen", 32'(udp_txen), 0);
    chk("t5_addr", 32'(udp_tx_addr), 0);
    chk("t5_so", 32'(so), 0);
    chk("t5_len", 32'(udp_tx_len), 0);
    chk("t5_req", 32'(udp_tx_req), 0);
    rst = 1'b0;
    flush();
    repeat (3) tick();
    chk("t5_no_more_wr", wn, 10);
    start(3, 3);
    wait_req(20);
    chk("t5_wn", wn, 3);
    chk("t5_last_a", last_a, 2);
    done_pulse();

    rxn = 0;
    repeat (20) tick();
    chk("t6_hold_fd", 32'(fd), 1);
    chk("t6_no_reads", rxn, 0);
    chk("t6_no_req", 32'(udp_tx_req), 0);
    fs = 1'b0;
    tick();
    chk("t6_idle", 32'(fd), 0);
    start(2, 2);
    wait_req(20);
    chk("t6_req_cyc", cyc, t0 + 5);
    chk("t6_wn", wn, 2);
    done_pulse();
    fs = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/fifod2mac.md
# fifod2mac

Transmit-side data mover between the device-data FIFO (fifod) and the UDP transmit buffer of the Ethernet MAC. On a start request from the control FSM it reads a given number of payload bytes out of fifod and writes them into the MAC TX buffer at addresses 0..N-1. It then presents the UDP length, requests transmission and waits for the MAC to finish. It is the transmit counterpart of the receive path that moves UDP RX buffer contents into the command FIFO.

## Interface
- MAX_LEN, 1472: largest payload in bytes; longer requests are clamped.
- HDR_LEN, 8: UDP header bytes added to form udp_tx_len.

- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- fs  in  1  start request from control FSM, level.
- fd  out  1  done; high while in LAST.
- so  out  11  status; mirrors udp_tx_addr.
- dev_tx_len  in  12  payload byte count; sampled in IDLE when fs is seen.
- fifod_rxd  in  8  FIFO read data; valid the cycle after fifod_rxen (standard, non-FWFT).
- fifod_empty  in  1  FIFO empty flag.
- fifod_rxen  out  1  FIFO read enable (combinational).
- udp_txd  out  8  TX buffer write data; equals fifod_rxd.
- udp_tx_addr  out  11  TX buffer write address, registered.
- udp_txen  out  1  TX buffer write enable, registered.
- udp_tx_len  out  16  UDP length = payload + HDR_LEN, registered.
- udp_tx_req  out  1  transmit request to MAC, registered.
- udp_tx_done  in  1  one-cycle pulse from MAC when the frame is sent.

## Operation
- States: IDLE, LOAD, WORK, SEND, LAST.
- IDLE: counters are zero. If fs is high, latch len_r = min(dev_tx_len, MAX_LEN) and go to LOAD.
- LOAD:
  - Register udp_tx_len = len_r + HDR_LEN (16-bit, zero-extended).
  - If len_r == 0, go to LAST. No FIFO reads, no writes, no request.
  - Otherwise go to WORK.
- WORK:
  - fifod_rxen = (rd_cnt < len_r) && !fifod_empty.
  - rd_cnt increments on each cycle that fifod_rxen is high.
  - udp_txen <= fifod_rxen, a one-cycle delay.
  - On each cycle with udp_txen high, the byte is written at udp_tx_addr. udp_tx_addr then increments.
  - When udp_txen is high and udp_tx_addr == len_r-1, go to SEND.
- SEND: udp_tx_req stays high. On udp_tx_done, clear udp_tx_req and go to LAST.
- LAST: fd=1. When fs goes low, go to IDLE. While fs stays high, remain in LAST; no restart.
- fs going low during LOAD/WORK/SEND is ignored; the frame completes.
- udp_tx_done outside SEND is ignored.
- Outside WORK, fifod_rxen=0. udp_txen is forced low in every state other than WORK, except for the final delayed write.
- udp_tx_addr holds its final value through SEND/LAST and clears in IDLE.

## Timing
- Reset: the cycle after rst is sampled high:
  - state=IDLE, fd=0, fifod_rxen=0, udp_txen=0.
  - udp_tx_addr=0, so=0, udp_tx_len=0, udp_tx_req=0.
  - rd_cnt=0, len_r=0.
- A reset mid-operation abandons the frame. No further reads, writes or request follow.
- Latency (fs sampled in cycle T):
  - LOAD in T+1, WORK in T+2.
  - First fifod_rxen in T+2 if the FIFO is non-empty.
  - First udp_txen in T+3.
- Throughput: one byte per cycle while the FIFO is non-empty.
  - With no stalls, the last write is in cycle T+2+len_r.
  - udp_tx_req rises in the following cycle.
- Empty stall: fifod_rxen drops in the same cycle fifod_empty is high. udp_txen drops one cycle later. Addresses do not skip.
- Empty is re-evaluated every cycle. Reads resume in the first non-empty cycle.
- udp_tx_req falls in the cycle after udp_tx_done is sampled; fd rises in that same cycle.
- Widths:
  - rd_cnt and the address counter are 11 bits. len_r is at most 1472 < 2048, so there is no wrap.
  - dev_tx_len above MAX_LEN, up to 4095, clamps to MAX_LEN.

## Test plan
- dev_tx_len=4, FIFO holds A0..A3, fs held high:
  - fifod_rxen for 4 cycles starting at T+2.
  - udp_txen at T+3..T+6 with addr 0..3 and data A0..A3.
  - udp_tx_len=12, then udp_tx_req. Pulse udp_tx_done: fd=1. Drop fs: IDLE.
- dev_tx_len=6, fifod_empty high for 3 cycles after the 2nd byte:
  - Writes pause for exactly 3 cycles.
  - Addresses are 0..5 contiguous, data in order, exactly 6 reads.
- dev_tx_len=0: goes straight to LAST at T+2. No fifod_rxen, no udp_txen, no udp_tx_req, udp_tx_len=8.
- dev_tx_len=2000: exactly 1472 writes with last address 1471, udp_tx_len=1480.
- rst asserted for one cycle during WORK after 10 writes: next cycle all outputs are at their reset values. A new fs with dev_tx_len=3 writes at addresses 0..2.
- fs kept high through LAST for 20 cycles, then dropped and re-raised: no second frame until fs has been low. The second frame then starts normally.
